// File: rtl/audio_interp_up.sv
// audio_interp_up: linear-interpolating upsampler from a low-rate sample stream
// (one sample per DIV clocks) to a per-clock output. Input samples queue in a
// small FIFO. Each period a restoring divider finds the per-clock slope, and the
// output is rebuilt from running quotient/remainder accumulators.
module audio_interp_up #(
  parameter int DIV        = 224,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out,
  output logic        tick,
  output logic        underrun
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0]    DivLast  = 10'(DIV - 1);
  localparam logic [10:0]   DivTrial = 11'(DIV);
  localparam logic [PW-1:0] PtrLast  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CntFull  = CW'(FIFO_DEPTH);

  typedef enum logic {DivIdle, DivBusy} divState_e;

  logic [15:0]   fifoMem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  logic [15:0]   head;

  logic [9:0]    phase_q;
  logic          boundary, phaseZero;

  divState_e     divState_q;
  logic [4:0]    divCnt_q;
  logic [15:0]   divQuo_q;
  logic [9:0]    divRem_q;
  logic [10:0]   divTrial;
  logic          divGe;
  logic          diffNeg_q, armed_q;
  logic [16:0]   diffD;
  logic [15:0]   absDiff;

  logic [15:0]   prev_q, cur_q;
  logic [15:0]   slopeQ_q;
  logic [9:0]    slopeR_q;
  logic          slopeNeg_q;
  logic          tick_q, underrun_q;

  logic [16:0]   qacc_q, qaccD;
  logic [9:0]    racc_q, raccD;
  logic [10:0]   raccSum;
  logic          carry;
  logic [17:0]   prevExt, stepExt;
  logic [15:0]   out_q, outD;

  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign boundary  = (phase_q == DivLast);
  assign phaseZero = (phase_q == 10'd0);
  assign pop       = boundary & armed_q;
  assign head      = fifoMem[rdPtr_q];

  assign out      = out_q;
  assign tick     = tick_q;
  assign underrun = underrun_q;

  // FIFO storage is written on every accepted push; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr_q] <= in_data;
  end

  // FIFO pointers and fill level; a simultaneous push and pop leaves the fill unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= (wrPtr_q == PtrLast) ? '0 : wrPtr_q + PW'(1);
      if (pop)  rdPtr_q <= (rdPtr_q == PtrLast) ? '0 : rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Free-running phase counter, 0..DIV-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) phase_q <= '0;
    else        phase_q <= boundary ? '0 : phase_q + 10'd1;
  end

  // Next segment's difference (head - cur) sampled at phase 0, split into sign and magnitude.
  always_comb begin
    diffD    = empty ? 17'd0 : ({head[15], head} - {cur_q[15], cur_q});
    absDiff  = diffD[16] ? 16'(17'd0 - diffD) : diffD[15:0];
    divTrial = {divRem_q, divQuo_q[15]};
    divGe    = (divTrial >= DivTrial);
  end

  // Restoring divider: loads |diff| at phase 0, one quotient bit per clock, idle after 16 steps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divState_q <= DivIdle;
      divCnt_q   <= '0;
      divQuo_q   <= '0;
      divRem_q   <= '0;
      diffNeg_q  <= 1'b0;
      armed_q    <= 1'b0;
    end else if (phaseZero) begin
      diffNeg_q  <= diffD[16];
      armed_q    <= ~empty;
      divQuo_q   <= absDiff;
      divRem_q   <= '0;
      divCnt_q   <= 5'd16;
      divState_q <= DivBusy;
    end else if (divState_q == DivBusy) begin
      if (divGe) begin
        divRem_q <= 10'(divTrial - DivTrial);
        divQuo_q <= {divQuo_q[14:0], 1'b1};
      end else begin
        divRem_q <= divTrial[9:0];
        divQuo_q <= {divQuo_q[14:0], 1'b0};
      end
      divCnt_q <= divCnt_q - 5'd1;
      if (divCnt_q == 5'd1) divState_q <= DivIdle;
    end
  end

  // At each boundary advance the segment endpoints and latch the slope, or flag an underrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      cur_q      <= '0;
      slopeQ_q   <= '0;
      slopeR_q   <= '0;
      slopeNeg_q <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else if (boundary) begin
      prev_q     <= cur_q;
      tick_q     <= 1'b1;
      underrun_q <= ~armed_q;
      if (armed_q) begin
        cur_q      <= head;
        slopeQ_q   <= divQuo_q;
        slopeR_q   <= divRem_q;
        slopeNeg_q <= diffNeg_q;
      end else begin
        slopeQ_q   <= '0;
        slopeR_q   <= '0;
        slopeNeg_q <= 1'b0;
      end
    end else begin
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end
  end

  // Next accumulator step: racc carries into qacc whenever it reaches DIV, giving floor(|d|*k/DIV).
  always_comb begin
    raccSum = {1'b0, racc_q} + {1'b0, slopeR_q};
    carry   = (raccSum >= DivTrial);
    raccD   = carry ? 10'(raccSum - DivTrial) : raccSum[9:0];
    qaccD   = qacc_q + {1'b0, slopeQ_q} + {16'd0, carry};
    prevExt = {{2{prev_q[15]}}, prev_q};
    stepExt = {1'b0, qaccD};
    outD    = slopeNeg_q ? 16'(prevExt - stepExt) : 16'(prevExt + stepExt);
  end

  // Accumulators and registered output; the boundary restarts the segment at the new prev.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      qacc_q <= '0;
      racc_q <= '0;
      out_q  <= '0;
    end else if (boundary) begin
      qacc_q <= '0;
      racc_q <= '0;
      out_q  <= cur_q;
    end else begin
      qacc_q <= qaccD;
      racc_q <= raccD;
      out_q  <= outD;
    end
  end

endmodule

// File: tb/tb_audio_interp_up.sv
// Directed bench for audio_interp_up: expectations are queued by cycle number
// and compared when the DUT reaches that cycle.
module tb_audio_interp_up;

  localparam int K_OUT   = 0;
  localparam int K_TICK  = 1;
  localparam int K_UNDER = 2;
  localparam int K_RDY   = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] expVal;
    string       tag;
  } sbEntry_t;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic [15:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out;
  logic        tick;
  logic        underrun;

  int       cyc    = 0;
  int       errors = 0;
  int       checks = 0;
  sbEntry_t sb[$];

  audio_interp_up #(.DIV(224), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .tick     (tick),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; equals the DUT phase modulo 224.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [15:0] sampleOutput(input int kind);
    case (kind)
      K_OUT:   return out;
      K_TICK:  return {15'd0, tick};
      K_UNDER: return {15'd0, underrun};
      default: return {15'd0, in_ready};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int at, input logic [15:0] obs,
                             input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, at, $signed(obs), $signed(expv));
    end
  endtask

  task automatic expectAt(input int c, input int kind, input int v, input string tag);
    sbEntry_t e;
    e.cyc    = c;
    e.kind   = kind;
    e.expVal = 16'(v);
    e.tag    = tag;
    sb.push_back(e);
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic applyStimulus(input int c, input int v);
    waitCycle(c);
    in_data  = 16'(v);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Pop and compare every expectation due at the current cycle.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          checkOutput(sb[i].tag, cyc, sampleOutput(sb[i].kind), sb[i].expVal);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    int guard;
    $display("[TB] audio_interp_up bench start");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("in-reset out", 0, out, 16'd0);
    checkOutput("in-reset in_ready", 0, {15'd0, in_ready}, 16'd1);
    checkOutput("in-reset tick", 0, {15'd0, tick}, 16'd0);
    checkOutput("in-reset underrun", 0, {15'd0, underrun}, 16'd0);

    // first period after release: empty FIFO, underrun at the first boundary
    expectAt(0,   K_OUT,   0, "release out");
    expectAt(0,   K_RDY,   1, "release in_ready");
    expectAt(223, K_TICK,  0, "tick before boundary");
    expectAt(224, K_TICK,  1, "first tick");
    expectAt(224, K_UNDER, 1, "first underrun");
    expectAt(224, K_OUT,   0, "out stays 0");
    expectAt(225, K_TICK,  0, "tick one cycle");
    expectAt(225, K_UNDER, 0, "underrun one cycle");
    expectAt(448, K_TICK,  1, "second tick");
    expectAt(448, K_UNDER, 0, "armed no underrun");
    // ramp 0 -> 22400 in steps of 100
    expectAt(672,  K_OUT, 0,     "ramp-up k0");
    expectAt(673,  K_OUT, 100,   "ramp-up k1");
    expectAt(700,  K_OUT, 2800,  "ramp-up k28");
    expectAt(895,  K_OUT, 22300, "ramp-up k223");
    expectAt(896,  K_OUT, 22400, "ramp-up held");
    expectAt(896,  K_UNDER, 1,   "ramp-up underrun");
    expectAt(1000, K_OUT, 22400, "ramp-up flat");
    expectAt(1120, K_UNDER, 1,   "flat underrun");
    expectAt(1120, K_OUT, 22400, "flat out");
    // 22400 -> 0, then 0 -> -1000 with truncation toward zero
    expectAt(1344, K_OUT, 22400, "down k0");
    expectAt(1345, K_OUT, 22300, "down k1");
    expectAt(1568, K_OUT, 0,     "trunc k0");
    expectAt(1569, K_OUT, -4,    "trunc k1");
    expectAt(1570, K_OUT, -8,    "trunc k2");
    expectAt(1571, K_OUT, -13,   "trunc k3");
    expectAt(1680, K_OUT, -500,  "trunc k112");
    expectAt(1791, K_OUT, -995,  "trunc k223");
    expectAt(1792, K_OUT, -1000, "trunc held");
    expectAt(1792, K_UNDER, 1,   "trunc underrun");
    // -1000 -> 1234, then starve with cur = 1234
    expectAt(2240, K_OUT, -1000, "up1234 k0");
    expectAt(2352, K_OUT, 117,   "up1234 k112");
    expectAt(2464, K_OUT, 1234,  "starve held");
    expectAt(2464, K_UNDER, 1,   "starve underrun a");
    expectAt(2465, K_UNDER, 0,   "starve underrun pulse");
    expectAt(2600, K_OUT, 1234,  "starve flat");
    expectAt(2688, K_UNDER, 1,   "starve underrun b");
    expectAt(2688, K_TICK, 1,    "starve tick");
    expectAt(2689, K_UNDER, 0,   "starve underrun c");
    // FIFO full: five back-to-back pushes
    expectAt(2703, K_RDY, 1, "ready before 4th");
    expectAt(2704, K_RDY, 0, "full after 4th");
    expectAt(3135, K_RDY, 0, "still full");
    expectAt(3136, K_RDY, 1, "ready after pop");
    expectAt(3137, K_RDY, 0, "5th accepted");
    expectAt(3136, K_OUT, 1234, "from 1234 k0");
    expectAt(3137, K_OUT, 1237, "from 1234 k1");
    expectAt(3248, K_OUT, 1617, "from 1234 k112");
    expectAt(3360, K_OUT, 2000, "order 2000");
    expectAt(3361, K_OUT, 2004, "2000 to 3000 k1");
    // push on the boundary with three queued samples
    expectAt(3583, K_RDY, 1,    "depth-1 ready");
    expectAt(3584, K_RDY, 1,    "push+pop ready");
    expectAt(3584, K_TICK, 1,   "push+pop tick");
    expectAt(3584, K_OUT, 3000, "order 3000");
    expectAt(3808, K_OUT, 4000, "order 4000");
    expectAt(4032, K_OUT, 5000, "order 5000");
    expectAt(4256, K_OUT, 6000, "order 6000");
    expectAt(4368, K_OUT, 6500, "6000 to 7000 k112");
    expectAt(4385, K_RDY, 0,    "refill full");

    @(posedge clk);
    #2 reset = 1'b1;

    applyStimulus(10, 0);
    applyStimulus(11, 22400);
    applyStimulus(900, 0);
    applyStimulus(901, -1000);
    applyStimulus(1800, 1234);

    waitCycle(2700);
    in_valid = 1'b1;
    in_data  = 16'd2000;
    @(negedge clk) in_data = 16'd3000;
    @(negedge clk) in_data = 16'd4000;
    @(negedge clk) in_data = 16'd5000;
    @(negedge clk) in_data = 16'd6000;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    assert (guard < 1000) else begin
      errors++;
      $error("[TB] FAIL 5th-push wait observed=%0d cycles expected=<1000", guard);
    end

    applyStimulus(3583, 7000);

    applyStimulus(4380, 8000);
    applyStimulus(4381, 9000);
    applyStimulus(4382, 10000);
    applyStimulus(4383, 11000);

    // reset mid-segment with a full FIFO
    waitCycle(4400);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid-reset out", 4400, out, 16'd0);
    checkOutput("mid-reset in_ready", 4400, {15'd0, in_ready}, 16'd1);
    checkOutput("mid-reset tick", 4400, {15'd0, tick}, 16'd0);

    expectAt(0,   K_OUT,   0, "re-release out");
    expectAt(223, K_TICK,  0, "re tick before");
    expectAt(224, K_TICK,  1, "re tick");
    expectAt(224, K_UNDER, 1, "re underrun (queue discarded)");
    expectAt(224, K_OUT,   0, "re out 0");
    expectAt(225, K_TICK,  0, "re tick pulse");
    expectAt(300, K_OUT,   0, "re out still 0");
    expectAt(448, K_UNDER, 1, "re underrun again");

    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    waitCycle(460);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard-drain observed=%0d pending expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_interp_up.md
AUDIO_INTERP_UP -- requirements
Module: audio_interp_up

Interface
REQ-001 Parameter DIV, default 224, clocks per input sample period (~96 kHz on the NES core clock); the legal range SHALL be 32..1023.
REQ-002 Parameter FIFO_DEPTH, default 4, input sample FIFO entries; the legal range SHALL be 2..16.
REQ-003 Port clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port in_data  input  16  signed two's-complement sample at the low rate.
REQ-006 Port in_valid  input  1  in_data is valid this cycle.
REQ-007 Port in_ready  output  1  the FIFO can accept a sample; a push SHALL occur when in_valid and in_ready are both 1.
REQ-008 Port out  output  16  signed interpolated sample, updated every clk.
REQ-009 Port tick  output  1  one-cycle pulse at each period boundary.
REQ-010 Port underrun  output  1  one-cycle pulse at a period boundary where no sample was consumed.

Function
REQ-011 The FIFO SHALL be synchronous, with in_ready = !full.
- A push while full SHALL be impossible by construction.
- A push and a pop in the same cycle SHALL both take effect and leave the fill level unchanged.
REQ-012 A free-running phase counter SHALL count 0..DIV-1, wrap to 0, and run from the first clock after reset is released.
REQ-013 Registers prev and cur (16-bit signed) SHALL hold the current segment endpoints.
REQ-014 At phase 0 the FIFO head is sampled:
- If the FIFO is non-empty, diff = head - cur (17-bit signed) and the armed flag is set.
- If the FIFO is empty, diff = 0 and armed is cleared.
REQ-015 A sequential restoring divider SHALL start at phase 0 on |diff|.
- It SHALL produce quotient q = |diff| div DIV and remainder r = |diff| mod DIV.
- It SHALL complete by phase 20.
- It SHALL be idle otherwise.
REQ-016 A sample arriving after phase 0 SHALL NOT be consumed in the current period.
REQ-017 At phase DIV-1 (boundary), tick SHALL pulse and prev <= cur.
- If armed: cur <= head, the FIFO pops, and the q/r/sign results are latched as the active slope.
- If not armed: cur is unchanged, the slope is 0, and underrun pulses.
REQ-018 Within a segment, the phase-k value SHALL be prev + sign*floor(|cur-prev|*k/DIV), with k = 0..DIV-1 counted from the boundary.
- Rounding is toward zero.
- The value is computed by incremental accumulation: qacc += q and racc += r each clock; when racc >= DIV, racc -= DIV and qacc += 1.
- No multiplier or divider SHALL be used on the output path.
REQ-019 out SHALL be registered, carrying one clock of latency from phase to out.
- At phase 0 of each segment, out SHALL equal prev exactly.
- out SHALL stay within [min(prev,cur), max(prev,cur)] and never overflow 16 bits.
REQ-020 The accumulators SHALL clear at every boundary.
REQ-021 Simultaneous events (push, pop and boundary in one cycle) SHALL all take effect with no sample lost or duplicated.

Reset
REQ-022 While reset=0, all state SHALL clear asynchronously:
- prev, cur, out, diff, accumulators and divider state = 0.
- phase = 0; armed = 0; FIFO empty.
- in_ready = 1; tick = 0; underrun = 0.
REQ-023 Reset asserted mid-segment SHALL force out = 0 without waiting for a clock edge, and SHALL discard all queued samples.
REQ-024 After release, the first boundary with an empty FIFO SHALL pulse underrun, and out SHALL stay 0.

Verification
REQ-025 Reset: assert reset=0 mid-run -> out=0, in_ready=1 and tick=0 immediately; 224 clocks after release, tick pulses once and underrun pulses once.
REQ-026 Ramp up: push 0 then 22400 before their phase-0 samplings, then stop pushing -> the segment after cur becomes 22400 reads out = 0, 100, 200, ..., 22300, and then 22400 is held flat.
REQ-027 Ramp down, truncation: prev=0, cur=-1000 -> out = 0, -4, -8, -13 at k = 0..3; -500 at k=112; -995 at k=223.
REQ-028 FIFO full: push 5 samples back-to-back with DIV=224 and FIFO_DEPTH=4 -> in_ready=0 after the 4th push; the 5th is accepted in the cycle after the next pop; no sample is lost.
REQ-029 Underrun: stop pushing with cur=1234 -> after one settling segment out holds 1234, underrun pulses once per 224 clocks, and the next pushed sample ramps from 1234.
REQ-030 Simultaneous events: push on the exact boundary cycle with the FIFO at depth-1 -> the pop and push both occur, fill is unchanged, in_ready stays 1, and sample order is preserved.
